// File: rtl/array_pkg.sv
// Shared types and helpers for the systolic array result path.
package array_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } collector_state_t;

    // Bit offset of lane 'lane' inside a row of 'dw'-bit lanes.
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with fall-through head; a write is accepted when full if a read frees a slot.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  logic [WIDTH-1:0]             i_wr_data,
    input  logic                         i_rd_en,
    output logic [WIDTH-1:0]             o_rd_data_c,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full_c,
    output logic                         o_empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign w_do_rd = i_rd_en && (r_count != '0);
    assign w_do_wr = i_wr_en && ((r_count != CW'(DEPTH)) || w_do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_mem[r_wr_ptr] <= i_wr_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data_c = r_mem[r_rd_ptr];
    assign o_count     = r_count;
    assign o_full_c    = (r_count == CW'(DEPTH));
    assign o_empty_c   = (r_count == '0);

endmodule

// File: rtl/array_result_collector.sv
// De-skews the bottom-row Y stream of the PE array into whole rows and buffers them for writeback.
// Optional COLLECTOR_RELU_EN clamps negative lanes to zero at FIFO write.
module array_result_collector
    import array_pkg::*;
#(
    parameter int unsigned M          = 5,
    parameter int unsigned N          = 3,
    parameter int unsigned K          = 4,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIRST_LAT  = N,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DATA_WIDTH*K-1:0] Y,
    output logic [DATA_WIDTH*K-1:0] y_data,
    output logic                    y_valid,
    input  logic                    y_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow
);

    localparam int unsigned ROW_W     = DATA_WIDTH * K;
    localparam int unsigned CAP_START = FIRST_LAT + K - 1;
    localparam bit          SKIP_WAIT = (CAP_START < 2);
    localparam int unsigned WAIT_LAST = SKIP_WAIT ? 0 : CAP_START - 2;
    localparam int unsigned CNT_MAX   = (CAP_START > M) ? CAP_START : M;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned FCNT_W    = $clog2(FIFO_DEPTH + 1);

    collector_state_t   r_state;
    collector_state_t   w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;

    logic [ROW_W-1:0]   w_aligned;
    logic [ROW_W-1:0]   w_wr_data;
    logic [ROW_W-1:0]   w_rd_data;
    logic [FCNT_W-1:0]  w_fifo_count;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_done;
    logic               w_start_acc;
    logic               w_will_empty;

    // Lane j is delayed K-1-j cycles so all lanes of a vector line up with lane K-1.
    for (genvar j = 0; j < K; j++) begin : g_lane
        localparam int unsigned STAGES = K - 1 - j;
        localparam int unsigned LSB    = lane_lsb(j, DATA_WIDTH);

        logic [DATA_WIDTH-1:0] w_lane;

        if (STAGES == 0) begin : g_direct
            assign w_aligned[LSB +: DATA_WIDTH] = Y[LSB +: DATA_WIDTH];
        end else begin : g_skew
            logic [DATA_WIDTH-1:0] r_skew [STAGES];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned s = 0; s < STAGES; s++) begin
                        r_skew[s] <= '0;
                    end
                end else begin
                    r_skew[0] <= Y[LSB +: DATA_WIDTH];
                    for (int unsigned s = 1; s < STAGES; s++) begin
                        r_skew[s] <= r_skew[s-1];
                    end
                end
            end

            assign w_aligned[LSB +: DATA_WIDTH] = r_skew[STAGES-1];
        end

        assign w_lane = w_aligned[LSB +: DATA_WIDTH];
`ifdef COLLECTOR_RELU_EN
        assign w_wr_data[LSB +: DATA_WIDTH] = w_lane[DATA_WIDTH-1] ? '0 : w_lane;
`else
        assign w_wr_data[LSB +: DATA_WIDTH] = w_lane;
`endif
    end

    sync_fifo #(
        .WIDTH (ROW_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_push),
        .i_wr_data   (w_wr_data),
        .i_rd_en     (w_pop),
        .o_rd_data_c (w_rd_data),
        .o_count     (w_fifo_count),
        .o_full_c    (w_fifo_full),
        .o_empty_c   (w_fifo_empty)
    );

    assign y_valid = !w_fifo_empty;
    assign y_data  = w_rd_data;
    assign w_pop   = y_valid && y_ready;
    assign w_drop  = w_push && w_fifo_full && !w_pop;

    // DRAIN finishes on the cycle the last buffered row leaves.
    assign w_will_empty = (w_fifo_count == '0) || ((w_fifo_count == FCNT_W'(1)) && w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)                        w_next_state = SKIP_WAIT ? CAPTURE : WAIT;
            WAIT:    if (r_cnt == CNT_W'(WAIT_LAST))   w_next_state = CAPTURE;
            CAPTURE: if (r_cnt == CNT_W'(M - 1))       w_next_state = DRAIN;
            DRAIN:   if (w_will_empty)                 w_next_state = IDLE;
            default:                                   w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_push      = 1'b0;
        w_done      = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            IDLE:    w_start_acc = start;
            CAPTURE: w_push      = 1'b1;
            DRAIN:   w_done      = w_will_empty;
            default: ;
        endcase
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state != w_next_state) begin
            r_cnt <= '0;
        end else if ((r_state == WAIT) || (r_state == CAPTURE)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_busy <= (w_next_state != IDLE);
            r_done <= w_done;
            if (w_start_acc) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_array_result_collector.sv
// Randomized bench for array_result_collector against a queue-based reference model.
module tb_array_result_collector;

    localparam int M         = 5;
    localparam int N         = 3;
    localparam int K         = 4;
    localparam int DW        = 32;
    localparam int FIRST_LAT = 3;
    localparam int DEPTH     = 4;
    localparam int ROW_W     = DW * K;
    localparam int CAP       = FIRST_LAT + K - 1;
    localparam int HIST      = 4096;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ROW_W-1:0] Y;
    logic [ROW_W-1:0] y_data;
    logic             y_valid;
    logic             y_ready;
    logic             busy;
    logic             done;
    logic             overflow;

    always #5 clk = ~clk;

    array_result_collector #(
        .M          (M),
        .N          (N),
        .K          (K),
        .DATA_WIDTH (DW),
        .FIRST_LAT  (FIRST_LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .Y        (Y),
        .y_data   (y_data),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .busy     (busy),
        .done     (done),
        .overflow (overflow)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Driver controls
    int            job_c0      = -100000;
    int            rdy_mode    = 0;
    int            restart_off = 0;
    int            rst_off     = 0;
    int            obs_xfer    = 0;
    logic [DW-1:0] vec [M][K];

    // Reference model: rows in flight, job status, history of driven Y
    logic [ROW_W-1:0] mdl_q [$];
    bit               mdl_active = 1'b0;
    bit               mdl_done   = 1'b0;
    bit               mdl_ovf    = 1'b0;
    int               mdl_t0     = 0;
    int               mdl_drops  = 0;
    logic [ROW_W-1:0] yhist [HIST];

    task automatic check_eq(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] relu_row(input logic [ROW_W-1:0] row);
        logic [ROW_W-1:0] r;
        r = row;
`ifdef COLLECTOR_RELU_EN
        for (int j = 0; j < K; j++) begin
            if (r[j*DW + DW - 1]) r[j*DW +: DW] = '0;
        end
`endif
        return r;
    endfunction

    // Row completing in cycle c: lane j was on the bus K-1-j cycles earlier.
    function automatic logic [ROW_W-1:0] expected_row(input int c);
        logic [ROW_W-1:0] r;
        logic [ROW_W-1:0] h;
        r = '0;
        for (int j = 0; j < K; j++) begin
            h = yhist[c - (K - 1 - j)];
            r[j*DW +: DW] = h[j*DW +: DW];
        end
        return relu_row(r);
    endfunction

    task automatic check_outputs();
        check_eq("y_valid", ROW_W'(y_valid), ROW_W'(mdl_q.size() != 0));
        if (mdl_q.size() != 0) check_eq("y_data", y_data, mdl_q[0]);
        check_eq("busy", ROW_W'(busy), ROW_W'(mdl_active));
        check_eq("done", ROW_W'(done), ROW_W'(mdl_done));
        check_eq("overflow", ROW_W'(overflow), ROW_W'(mdl_ovf));
        if (y_valid && y_ready) obs_xfer++;
    endtask

    task automatic model_step();
        bit nd;
        int rel;
        nd = 1'b0;
        if (rst) begin
            mdl_q.delete();
            mdl_active = 1'b0;
            mdl_done   = 1'b0;
            mdl_ovf    = 1'b0;
        end else begin
            if (mdl_q.size() > 0 && y_ready) void'(mdl_q.pop_front());
            if (mdl_active) begin
                rel = cyc - mdl_t0;
                if (rel >= CAP && rel < CAP + M) begin
                    if (mdl_q.size() < DEPTH) begin
                        mdl_q.push_back(expected_row(cyc));
                    end else begin
                        mdl_ovf = 1'b1;
                        mdl_drops++;
                    end
                end else if (rel >= CAP + M && mdl_q.size() == 0) begin
                    mdl_active = 1'b0;
                    nd         = 1'b1;
                end
            end else if (start) begin
                mdl_active = 1'b1;
                mdl_t0     = cyc;
                mdl_ovf    = 1'b0;
                mdl_drops  = 0;
            end
            mdl_done = nd;
        end
    endtask

    task automatic do_cycle();
        int               rel;
        int               m;
        logic [ROW_W-1:0] yv;
        @(posedge clk);
        #1;
        rel   = cyc - job_c0;
        start = (rel == 0) || (restart_off > 0 && rel == restart_off);
        rst   = (rst_off > 0 && rel == rst_off);
        case (rdy_mode)
            0:       y_ready = 1'b1;
            1:       y_ready = (rel >= 16);
            2:       y_ready = (rel % 2 == 0);
            default: y_ready = ($urandom_range(0, 3) != 0);
        endcase
        for (int j = 0; j < K; j++) begin
            m = rel - FIRST_LAT - j;
            if (m >= 0 && m < M) yv[j*DW +: DW] = vec[m][j];
            else                 yv[j*DW +: DW] = $urandom;
        end
        Y          = yv;
        yhist[cyc] = yv;
        @(negedge clk);
        check_outputs();
        model_step();
        cyc++;
    endtask

    task automatic run_job(input int mode, input int len, input int rs_off, input int rt_off);
        int b;
        job_c0      = cyc;
        rdy_mode    = mode;
        restart_off = rt_off;
        rst_off     = rs_off;
        obs_xfer    = 0;
        repeat (len) do_cycle();
        rdy_mode = 0;
        b = 0;
        while (mdl_active && b < 60) begin
            do_cycle();
            b++;
        end
        if (rs_off == 0) check_eq("rows_out", ROW_W'(obs_xfer), ROW_W'(M - mdl_drops));
        rst_off     = 0;
        restart_off = 0;
    endtask

    task automatic fill_random();
        for (int m = 0; m < M; m++)
            for (int j = 0; j < K; j++) vec[m][j] = $urandom;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        y_ready = 1'b0;
        Y       = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_y_valid", ROW_W'(y_valid), '0);
        check_eq("rst_y_data", y_data, '0);
        check_eq("rst_busy", ROW_W'(busy), '0);
        check_eq("rst_done", ROW_W'(done), '0);
        check_eq("rst_overflow", ROW_W'(overflow), '0);

        // Directed ramp data, always ready
        for (int m = 0; m < M; m++)
            for (int j = 0; j < K; j++) vec[m][j] = 32'(16 * m + j);
        run_job(0, 20, 0, 0);

        // Stalled for the whole job: one row dropped, then drained
        fill_random();
        run_job(1, 30, 0, 0);

        // Alternating ready, with sign-boundary lane values (next start clears overflow)
        fill_random();
        vec[1][0] = 32'hFFFF_FFF0;
        vec[1][1] = 32'h0000_0010;
        vec[2][3] = 32'h8000_0000;
        vec[3][2] = 32'h7FFF_FFFF;
        run_job(2, 30, 0, 0);

        // Second start while busy is ignored
        fill_random();
        run_job(0, 20, 0, 4);

        // Reset mid-job, then a clean job
        fill_random();
        run_job(0, 12, 8, 0);
        fill_random();
        run_job(0, 20, 0, 0);

        // Random traffic
        for (int t = 0; t < 10; t++) begin
            fill_random();
            run_job(3, 40, 0, (t % 2 == 0) ? int'($urandom_range(1, 10)) : 0);
        end

        repeat (3) do_cycle();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
